// File: rtl/seg7_to_hex_rx_pkg.sv
// Shared constants for the 7-segment link: active-low code table {a,b,c,d,e,f,g},
// the blank pattern and the receiver state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_hex_rx_if.sv
// Decoded-digit output channel of the receiver.
// Handshake: a transfer happens at a rising edge where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0 the producer holds out_data
// unchanged; out_ready may be driven independently of out_valid.
interface seg7_to_hex_rx_if;

    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/seg7_to_hex_rx_lookup.sv
// Combinational decode of one active-low segment pattern to a hex digit.
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] hex
);

    // Table lookup; anything not in the table (including blank) is illegal
    always_comb begin
        legal = 1'b1;
        hex   = 4'h0;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_hex_rx.sv
// 7-segment receiver: qualifies a stable pattern for STABLE_CYCLES samples,
// reports each new digit once on the output channel, pulses err for illegal
// stable patterns and flags dropped digits in a sticky overrun bit.
module seg7_to_hex_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [6:0]             seg_in,
    input  logic                   clr_overrun,
    output logic                   err,
    output logic                   overrun,
    output state_t                 dbg_state,
    seg7_to_hex_rx_if.master       out_if
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    logic [6:0]       seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;

    logic       same;
    logic       blank_in;
    logic       qualify;
    logic       legal;
    logic [3:0] hex;
    logic       accept;
    logic       emit;
    logic       drop;

    seg7_lookup u_lookup (
        .seg   (seg_q),
        .legal (legal),
        .hex   (hex)
    );

    assign same     = (seg_in == seg_q);
    assign blank_in = (seg_in == SEG_BLANK);
    // Qualifies on the edge where the run length reaches STABLE_CYCLES;
    // seg_q equals seg_in here, so the lookup sees the qualified pattern.
    assign qualify  = enable && (state_q == SETTLE) && same && (cnt_q == STABLE - 1'b1);

    // Sample the bus and track how long the current pattern has been stable
    always_comb begin
        seg_d = seg_in;
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!blank_in) state_d = SETTLE;
                SETTLE: begin
                    if (blank_in)     state_d = IDLE;
                    else if (qualify) state_d = HOLD;
                end
                HOLD: begin
                    if (blank_in)     state_d = IDLE;
                    else if (!same)   state_d = SETTLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: emit/drop decision, handshake, error and overrun flags
    always_comb begin
        accept      = out_valid_q && out_if.out_ready;
        emit        = qualify && legal;
        drop        = emit && out_valid_q && !out_if.out_ready;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b0;
        end
        if (emit && !drop) begin
            out_data_d  = hex;
            out_valid_d = 1'b1;
        end
        err_d     = qualify && !legal;
        overrun_d = clr_overrun ? 1'b0 : (overrun_q | drop);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= SEG_BLANK;
            cnt_q       <= '0;
            out_data_q  <= 4'h0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign err              = err_q;
    assign overrun          = overrun_q;
    assign dbg_state        = state_q;

endmodule
